// File: rtl/instr_fetch_queue.sv
// Sequential-PC fetch front-end: one outstanding memory request, DEPTH-entry instr/PC FIFO, redirect flush.
// Ack at edge N is visible at the head after N; issue stalls when the FIFO would be full.
module instr_fetch_queue #(
   parameter int          DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic                       clk_i,
   input  logic                       rst_i,
   input  logic                       start_i,
   input  logic                       redirect_i,
   input  logic [31:0]                redirect_pc_i,
   output logic                       mem_req_o,
   output logic [31:0]                mem_addr_o,
   input  logic                       mem_ack_i,
   input  logic [31:0]                mem_data_i,
   output logic                       instr_valid_o,
   output logic [31:0]                instr_o,
   output logic [31:0]                pc_o,
   input  logic                       instr_ready_i,
   output logic [$clog2(DEPTH):0]     count_o
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;

   typedef enum logic [1:0] {IDLE, BUSY, DISCARD} state_t;

   state_t          state, state_next;
   logic [31:0]     fetch_pc, fetch_pc_next, addr_next;
   logic            req_next;
   logic [31:0]     instr_mem [DEPTH];
   logic [31:0]     pc_mem    [DEPTH];
   logic [AW-1:0]   wr_ptr, rd_ptr;
   logic [CW-1:0]   count, count_next;
   logic            ack, pop, push, room;

   assign ack  = mem_req_o & mem_ack_i;
   assign pop  = instr_valid_o & instr_ready_i;
   assign push = (state == BUSY) & ack & ~redirect_i;

   always_comb begin
      count_next = count;
      if (redirect_i)
         count_next = '0;
      else
         count_next = count + CW'(push) - CW'(pop);
   end

   // Issue only if the slot will still be free once this edge's push/pop settle.
   assign room = start_i & ~redirect_i & (count_next < CW'(DEPTH));

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i)
         state <= IDLE;
      else
         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         IDLE: begin
            if (room)
               state_next = BUSY;
         end
         BUSY: begin
            if (redirect_i)
               state_next = ack ? IDLE : DISCARD;
            else if (ack)
               state_next = room ? BUSY : IDLE;
         end
         DISCARD: begin
            if (ack)
               state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_comb begin
      req_next      = (state_next != IDLE);
      addr_next     = mem_addr_o;
      fetch_pc_next = fetch_pc;
      if (state == IDLE && state_next == BUSY)
         addr_next = fetch_pc;
      else if (push && state_next == BUSY)
         addr_next = mem_addr_o + 32'd4;
      if (redirect_i)
         fetch_pc_next = redirect_pc_i;
      else if (push)
         fetch_pc_next = mem_addr_o + 32'd4;
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         mem_req_o  <= 1'b0;
         mem_addr_o <= RESET_PC;
         fetch_pc   <= RESET_PC;
      end else begin
         mem_req_o  <= req_next;
         mem_addr_o <= addr_next;
         fetch_pc   <= fetch_pc_next;
      end
   end

   always_ff @(posedge clk_i or negedge rst_i) begin
      if (!rst_i) begin
         for (int i = 0; i < DEPTH; i++) begin
            instr_mem[i] <= '0;
            pc_mem[i]    <= '0;
         end
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (redirect_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            instr_mem[wr_ptr] <= mem_data_i;
            pc_mem[wr_ptr]    <= mem_addr_o;
            wr_ptr            <= wr_ptr + AW'(1);
         end
         if (pop)
            rd_ptr <= rd_ptr + AW'(1);
         count <= count_next;
      end
   end

   assign instr_valid_o = (count != '0);
   assign instr_o       = instr_mem[rd_ptr];
   assign pc_o          = pc_mem[rd_ptr];
   assign count_o       = count;

endmodule
